// File: rtl/mtx_hop_sched_pkg.sv
// mtx_hop_pkg: shared constants for the MTX frequency-hop scheduler.
//   - FSM state encoding as it appears on mtx_state (IDLE/PILOT/DATA/GUARD)
//   - bit positions used on the front-panel debug GPIO when
//     MTX_HOP_GPIO_EN is defined
package mtx_hop_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PILOT = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  localparam int GPIO_HOP_CLK_BIT = 0;
  localparam int GPIO_HOP_RST_BIT = 1;
  localparam int GPIO_STATE_LSB   = 2;
  localparam int GPIO_DDR_MASK    = 'h00F;

endpackage

// File: rtl/mtx_symb_timer.sv
// mtx_symb_timer: symbol-period cycle counter.
// Counts 0..SYMB_LEN-1 while clear is low and flags the last cycle of each
// symbol on symb_end (combinational from the registered count).
// Ports:
//   clk      - clock
//   reset    - synchronous, active-high
//   clear    - holds the counter at 0 (scheduler idle)
//   symb_end - high on the final cycle of the current symbol
module mtx_symb_timer #(
  parameter int SYMB_LEN = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic symb_end
);

  localparam int CNT_W = (SYMB_LEN > 1) ? $clog2(SYMB_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMB_LEN - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign symb_end = !clear && (cnt == CNT_LAST);

endmodule

// File: rtl/mtx_hop_sched.sv
// mtx_hop_sched: frequency-hop transmit scheduler for the MTX datapath.
// A frame is one pilot symbol, ntx_bits BFSK data symbols (LSB first) and one
// guard symbol. The hop carrier advances every NSYMB symbols across NHOP
// channels; phase increments and hop strobes feed the NCO/mixer chain.
// Optional feature: define MTX_HOP_GPIO_EN to drive hop_clk, hop_rst and
// mtx_state onto fp_gpio_out[3:0] (fp_gpio_ddr = 0x00F); otherwise both
// GPIO outputs are tied to 0.
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   start, tx_bits, ntx_bits - frame request and payload (latched in IDLE)
//   busy, done             - frame in progress / one-cycle end-of-frame pulse
//   mtx_ph_inc, hop_ph_inc - modulated and carrier phase increments
//   nhop, symbN            - hop index and symbol index within the hop
//   ntx_bits_cnt           - data bits completed
//   hop_clk, hop_rst       - hop entry strobe / hop chain reset
//   mtx_state              - 0 IDLE, 1 PILOT, 2 DATA, 3 GUARD
//   fp_gpio_out, fp_gpio_ddr - debug GPIO
module mtx_hop_sched
  import mtx_hop_pkg::*;
#(
  parameter int PHASE_WIDTH   = 24,
  parameter int NSYMB_WIDTH   = 16,
  parameter int TX_BITS_WIDTH = 128,
  parameter int BIT_CNT_WIDTH = 7,
  parameter int REG_WIDTH     = 12,
  parameter int NHOP          = 8,
  parameter int NSYMB         = 9,
  parameter int SYMB_LEN      = 1024,
  parameter int BASE_PH_INC   = 0,
  parameter int HOP_PH_STEP   = 4096,
  parameter int FSK_DEV       = 256,
  localparam int HOP_W        = (NHOP > 1) ? $clog2(NHOP) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [TX_BITS_WIDTH-1:0] tx_bits,
  input  logic [BIT_CNT_WIDTH-1:0] ntx_bits,
  output logic                     busy,
  output logic                     done,
  output logic [PHASE_WIDTH-1:0]   mtx_ph_inc,
  output logic [PHASE_WIDTH-1:0]   hop_ph_inc,
  output logic [HOP_W-1:0]         nhop,
  output logic [NSYMB_WIDTH-1:0]   symbN,
  output logic [BIT_CNT_WIDTH-1:0] ntx_bits_cnt,
  output logic                     hop_clk,
  output logic                     hop_rst,
  output logic [1:0]               mtx_state,
  output logic [REG_WIDTH-1:0]     fp_gpio_out,
  output logic [REG_WIDTH-1:0]     fp_gpio_ddr
);

  localparam logic [PHASE_WIDTH-1:0] BASE_PH  = PHASE_WIDTH'(BASE_PH_INC);
  localparam logic [PHASE_WIDTH-1:0] STEP_PH  = PHASE_WIDTH'(HOP_PH_STEP);
  localparam logic [PHASE_WIDTH-1:0] DEV_PH   = PHASE_WIDTH'(FSK_DEV);
  localparam logic [HOP_W-1:0]       HOP_LAST = HOP_W'(NHOP - 1);
  localparam logic [NSYMB_WIDTH-1:0] SYMB_LAST = NSYMB_WIDTH'(NSYMB - 1);

  // BFSK around the carrier; wraps modulo 2^PHASE_WIDTH.
  function automatic logic [PHASE_WIDTH-1:0] fsk_mod(
    input logic [PHASE_WIDTH-1:0] carrier,
    input logic                   bit_val
  );
    fsk_mod = bit_val ? (carrier + DEV_PH) : (carrier - DEV_PH);
  endfunction

  logic                     symb_end;
  logic [TX_BITS_WIDTH-1:0] tx_sh;
  logic [BIT_CNT_WIDTH-1:0] ntx_q;

  logic [1:0]               state_d;
  logic                     done_d, hop_clk_d, hop_rst_d, load, shift;
  logic [PHASE_WIDTH-1:0]   mtx_d, hop_ph_d, step_ph;
  logic [HOP_W-1:0]         nhop_d;
  logic [NSYMB_WIDTH-1:0]   symb_d;
  logic [BIT_CNT_WIDTH-1:0] bits_d;
  logic [REG_WIDTH-1:0]     gpio_out_d, gpio_ddr_d;
  logic                     last_symb;

  mtx_symb_timer #(.SYMB_LEN(SYMB_LEN)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (mtx_state == ST_IDLE),
    .symb_end (symb_end)
  );

  always_comb begin
    state_d   = mtx_state;
    done_d    = 1'b0;
    hop_clk_d = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    mtx_d     = mtx_ph_inc;
    hop_ph_d  = hop_ph_inc;
    nhop_d    = nhop;
    symb_d    = symbN;
    bits_d    = ntx_bits_cnt;
    last_symb = (symbN == SYMB_LAST);
    // Carrier of the next symbol: steps only when this symbol closes a hop,
    // and returns to BASE_PH when the hop index wraps to 0.
    if (!last_symb)
      step_ph = hop_ph_inc;
    else if (nhop == HOP_LAST)
      step_ph = BASE_PH;
    else
      step_ph = hop_ph_inc + STEP_PH;

    if (mtx_state == ST_IDLE) begin
      if (start) begin
        state_d   = ST_PILOT;
        load      = 1'b1;
        nhop_d    = '0;
        symb_d    = '0;
        bits_d    = '0;
        hop_ph_d  = BASE_PH;
        mtx_d     = BASE_PH;
        hop_clk_d = 1'b1;
      end
    end else if (symb_end) begin
      if (mtx_state == ST_PILOT) begin
        if (ntx_q == '0) begin
          state_d = ST_GUARD;
          mtx_d   = step_ph;
        end else begin
          state_d = ST_DATA;
          mtx_d   = fsk_mod(step_ph, tx_sh[0]);
        end
      end else if (mtx_state == ST_DATA) begin
        shift  = 1'b1;
        bits_d = ntx_bits_cnt + BIT_CNT_WIDTH'(1);
        if (bits_d == ntx_q) begin
          state_d = ST_GUARD;
          mtx_d   = step_ph;
        end else begin
          // tx_sh[1] becomes the LSB once this symbol's shift lands.
          mtx_d   = fsk_mod(step_ph, tx_sh[1]);
        end
      end else begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      // The guard symbol ends the frame, so no hop step leaks into IDLE.
      if (mtx_state != ST_GUARD) begin
        symb_d    = last_symb ? '0 : symbN + NSYMB_WIDTH'(1);
        hop_ph_d  = step_ph;
        hop_clk_d = last_symb;
        if (last_symb)
          nhop_d = (nhop == HOP_LAST) ? '0 : nhop + HOP_W'(1);
      end
    end

    hop_rst_d = (state_d == ST_IDLE) || load;

`ifdef MTX_HOP_GPIO_EN
    gpio_out_d = '0;
    gpio_out_d[GPIO_HOP_CLK_BIT]     = hop_clk_d;
    gpio_out_d[GPIO_HOP_RST_BIT]     = hop_rst_d;
    gpio_out_d[GPIO_STATE_LSB +: 2]  = state_d;
    gpio_ddr_d = REG_WIDTH'(GPIO_DDR_MASK);
`else
    gpio_out_d = '0;
    gpio_ddr_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtx_state    <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      mtx_ph_inc   <= BASE_PH;
      hop_ph_inc   <= BASE_PH;
      nhop         <= '0;
      symbN        <= '0;
      ntx_bits_cnt <= '0;
      hop_clk      <= 1'b0;
      hop_rst      <= 1'b1;
      fp_gpio_out  <= '0;
      fp_gpio_ddr  <= '0;
    end else begin
      mtx_state    <= state_d;
      busy         <= (state_d != ST_IDLE);
      done         <= done_d;
      mtx_ph_inc   <= mtx_d;
      hop_ph_inc   <= hop_ph_d;
      nhop         <= nhop_d;
      symbN        <= symb_d;
      ntx_bits_cnt <= bits_d;
      hop_clk      <= hop_clk_d;
      hop_rst      <= hop_rst_d;
      fp_gpio_out  <= gpio_out_d;
      fp_gpio_ddr  <= gpio_ddr_d;
    end
  end

  // Payload register: only meaningful while a frame is in flight.
  always_ff @(posedge clk) begin
    if (load) begin
      tx_sh <= tx_bits;
      ntx_q <= ntx_bits;
    end else if (shift) begin
      tx_sh <= tx_sh >> 1;
    end
  end

endmodule

// File: tb/tb_mtx_hop_sched.sv
// Testbench for mtx_hop_sched: scoreboard of per-cycle expected frame
// outputs, produced by a symbol-level reference model, drained by a monitor.
module tb_mtx_hop_sched;

  localparam int L     = 4;
  localparam int NS    = 3;
  localparam int NH    = 4;
  localparam int BASE  = 1000;
  localparam int STEP  = 100;
  localparam int DEV   = 10;
  localparam int PW    = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [127:0]  tx_bits = '0;
  logic [6:0]    ntx_bits = '0;
  logic          busy, done, hop_clk, hop_rst;
  logic [PW-1:0] mtx_ph_inc, hop_ph_inc;
  logic [1:0]    nhop;
  logic [15:0]   symbN;
  logic [6:0]    ntx_bits_cnt;
  logic [1:0]    mtx_state;
  logic [11:0]   fp_gpio_out, fp_gpio_ddr;

  mtx_hop_sched #(
    .NHOP(NH), .NSYMB(NS), .SYMB_LEN(L),
    .BASE_PH_INC(BASE), .HOP_PH_STEP(STEP), .FSK_DEV(DEV)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tx_bits(tx_bits),
    .ntx_bits(ntx_bits), .busy(busy), .done(done), .mtx_ph_inc(mtx_ph_inc),
    .hop_ph_inc(hop_ph_inc), .nhop(nhop), .symbN(symbN),
    .ntx_bits_cnt(ntx_bits_cnt), .hop_clk(hop_clk), .hop_rst(hop_rst),
    .mtx_state(mtx_state), .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    bit            is_done;
    logic [1:0]    st;
    logic [PW-1:0] mtx;
    logic [PW-1:0] hph;
    int            hop;
    int            symb;
    int            bcnt;
    bit            hclk;
    bit            hrst;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   free_cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   rst_d = 1'b1;

  always @(posedge clk) begin
    cyc   = cyc + 1;
    rst_d = reset;
  end

  task automatic chk(input string nm, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, req);
    end
  endtask

  function automatic logic [11:0] gpio_exp(input logic [1:0] st, input bit hrst, input bit hclk);
`ifdef MTX_HOP_GPIO_EN
    return {8'd0, st, hrst, hclk};
`else
    return 12'd0;
`endif
  endfunction

  function automatic logic [11:0] ddr_exp();
`ifdef MTX_HOP_GPIO_EN
    return 12'h00F;
`else
    return 12'h000;
`endif
  endfunction

  // Reference model: frame of n bits whose pilot starts in monitor cycle e.
  task automatic push_frame(input int e, input int n, input logic [127:0] b);
    exp_t x;
    for (int s = 0; s < n + 2; s++) begin
      int h = (s / NS) % NH;
      logic [PW-1:0] hph = PW'(BASE + h * STEP);
      for (int c = 0; c < L; c++) begin
        x.cyc     = e + s * L + c;
        x.is_done = 1'b0;
        x.hph     = hph;
        x.hop     = h;
        x.symb    = s % NS;
        x.hclk    = (c == 0) && (s % NS == 0);
        x.hrst    = (s == 0) && (c == 0);
        if (s == 0) begin
          x.st = 2'd1; x.mtx = hph; x.bcnt = 0;
        end else if (s == n + 1) begin
          x.st = 2'd3; x.mtx = hph; x.bcnt = n;
        end else begin
          x.st   = 2'd2;
          x.bcnt = s - 1;
          x.mtx  = b[s-1] ? PW'(hph + PW'(DEV)) : PW'(hph - PW'(DEV));
        end
        exp_q.push_back(x);
      end
    end
    x = '{cyc: e + (n + 2) * L, is_done: 1'b1, st: 2'd0, mtx: '0, hph: '0,
          hop: 0, symb: 0, bcnt: 0, hclk: 1'b0, hrst: 1'b1};
    exp_q.push_back(x);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t x;
    if (!rst_d) begin
      if (busy || done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output_busy", busy, 0);
        end else begin
          x = exp_q.pop_front();
          chk("cycle", cyc, x.cyc);
          chk("busy", busy, !x.is_done);
          chk("done", done, x.is_done);
          chk("mtx_state", mtx_state, x.st);
          chk("hop_rst", hop_rst, x.hrst);
          chk("hop_clk", hop_clk, x.hclk);
          chk("fp_gpio_out", fp_gpio_out, gpio_exp(x.st, x.hrst, x.hclk));
          chk("fp_gpio_ddr", fp_gpio_ddr, ddr_exp());
          if (!x.is_done) begin
            chk("mtx_ph_inc", mtx_ph_inc, x.mtx);
            chk("hop_ph_inc", hop_ph_inc, x.hph);
            chk("nhop", nhop, x.hop);
            chk("symbN", symbN, x.symb);
            chk("ntx_bits_cnt", ntx_bits_cnt, x.bcnt);
          end
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          x = exp_q.pop_front();
          chk("missing_output_cycle", cyc, -1);
        end
        chk("idle_state", mtx_state, 0);
        chk("idle_hop_rst", hop_rst, 1);
        chk("idle_hop_clk", hop_clk, 0);
        chk("idle_gpio", fp_gpio_out, gpio_exp(2'd0, 1'b1, 1'b0));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic try_start(input int n, input logic [127:0] b);
    start    = 1'b1;
    ntx_bits = 7'(n);
    tx_bits  = b;
    if (cyc >= free_cyc) begin
      push_frame(cyc + 1, n, b);
      free_cyc = cyc + 1 + (n + 2) * L;
    end
    step();
    start    = 1'b0;
    tx_bits  = {$urandom, $urandom, $urandom, $urandom};
    ntx_bits = 7'($urandom);
  endtask

  task automatic wait_free(input int gap);
    while (cyc < free_cyc + gap) step();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      chk("drain_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mtx_ph_inc"}, mtx_ph_inc, BASE);
    chk({tag, "_hop_ph_inc"}, hop_ph_inc, BASE);
    chk({tag, "_nhop"}, nhop, 0);
    chk({tag, "_symbN"}, symbN, 0);
    chk({tag, "_ntx_bits_cnt"}, ntx_bits_cnt, 0);
    chk({tag, "_hop_clk"}, hop_clk, 0);
    chk({tag, "_hop_rst"}, hop_rst, 1);
    chk({tag, "_mtx_state"}, mtx_state, 0);
    chk({tag, "_fp_gpio_out"}, fp_gpio_out, 0);
    chk({tag, "_fp_gpio_ddr"}, fp_gpio_ddr, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int e;
    // Power-on reset held for three edges
    repeat (3) step();
    check_reset("por");
    reset = 1'b0;
    step();
    free_cyc = cyc;

    // Directed: 4 bits of 0xA, hop change lands on data bit 2
    try_start(4, 128'hA);
    drain();
    step();

    // Directed: 12 bits, hop index wraps back to 0
    try_start(12, rnd128());
    drain();
    step();

    // Zero-length frame, restart on the done cycle, ignored mid-frame starts
    try_start(0, rnd128());
    wait_free(0);
    try_start(3, rnd128());
    step();
    try_start(5, rnd128());
    step();
    try_start(1, rnd128());
    drain();
    step();

    // Reset during data bit 2, then a full frame
    try_start(6, rnd128());
    e = free_cyc - 8 * L;
    while (cyc < e + 3 * L + 1) step();
    reset = 1'b1;
    step();
    exp_q.delete();
    check_reset("midrst");
    reset = 1'b0;
    step();
    free_cyc = cyc;
    try_start(5, rnd128());
    drain();

    // Randomized frames with random gaps and stray start pulses
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1 && cyc < free_cyc - 2) begin
        step();
        try_start($urandom_range(0, 20), rnd128());
      end
      wait_free($urandom_range(0, 1) == 0 ? 0 : $urandom_range(1, 5));
      try_start($urandom_range(0, 20), rnd128());
    end
    drain();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
